// File: rtl/mux_4x1_8bits_unstripe.sv
// rtl/mux_4x1_8bits_unstripe.sv - four-lane byte un-striping mux with per-lane skew FIFOs
// Lanes are drained strictly in order 0,1,2,3; an empty lane stalls the sequencer.
module mux_4x1_8bits_unstripe #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset_L,
   input  logic [WIDTH-1:0] data_in0,
   input  logic [WIDTH-1:0] data_in1,
   input  logic [WIDTH-1:0] data_in2,
   input  logic [WIDTH-1:0] data_in3,
   input  logic             valid_in0,
   input  logic             valid_in1,
   input  logic             valid_in2,
   input  logic             valid_in3,
   output logic [WIDTH-1:0] data_out,
   output logic             valid_out,
   output logic [1:0]       lane_sel,
   output logic             overflow,
   output logic [3:0]       lane_full
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   typedef enum logic [1:0] {L0, L1, L2, L3} lane_t;
   lane_t state, state_nxt;

   logic [WIDTH-1:0] mem [4][DEPTH];
   logic [PW-1:0]    wptr [4];
   logic [PW-1:0]    rptr [4];
   logic [CW-1:0]    count [4];
   logic [WIDTH-1:0] din [4];
   logic [3:0]       vin;
   logic [3:0]       push;
   logic [3:0]       pop;
   logic             drop;
   logic [WIDTH-1:0] head;

   assign din[0]   = data_in0;
   assign din[1]   = data_in1;
   assign din[2]   = data_in2;
   assign din[3]   = data_in3;
   assign vin      = {valid_in3, valid_in2, valid_in1, valid_in0};
   assign lane_sel = state;

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) state <= L0;
      else          state <= state_nxt;
   end

   // Only the selected lane may be popped; an empty selected lane holds the pointer.
   always_comb begin
      state_nxt = state;
      pop       = '0;
      head      = mem[state][rptr[state]];
      if (count[state] != '0) begin
         pop[state] = 1'b1;
         case (state)
            L0: state_nxt = L1;
            L1: state_nxt = L2;
            L2: state_nxt = L3;
            L3: state_nxt = L0;
         endcase
      end
   end

   // A full lane still accepts a byte when its head leaves on the same edge.
   always_comb begin
      push      = '0;
      drop      = 1'b0;
      lane_full = '0;
      for (int n = 0; n < 4; n++) begin
         push[n]      = vin[n] && ((count[n] != FULL_CNT) || pop[n]);
         drop         = drop | (vin[n] & ~push[n]);
         lane_full[n] = (count[n] == FULL_CNT);
      end
   end

   always_ff @(posedge clk) begin
      for (int n = 0; n < 4; n++) begin
         if (push[n]) mem[n][wptr[n]] <= din[n];
      end
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         data_out  <= '0;
         valid_out <= 1'b0;
         overflow  <= 1'b0;
         for (int n = 0; n < 4; n++) begin
            wptr[n]  <= '0;
            rptr[n]  <= '0;
            count[n] <= '0;
         end
      end else begin
         valid_out <= |pop;
         if (|pop) data_out <= head;
         if (drop) overflow <= 1'b1;
         for (int n = 0; n < 4; n++) begin
            if (push[n]) wptr[n] <= wptr[n] + PW'(1);
            if (pop[n])  rptr[n] <= rptr[n] + PW'(1);
            if (push[n] && !pop[n])      count[n] <= count[n] + CW'(1);
            else if (!push[n] && pop[n]) count[n] <= count[n] - CW'(1);
         end
      end
   end
endmodule

// File: tb/tb_mux_4x1_8bits_unstripe.sv
// tb/tb_mux_4x1_8bits_unstripe.sv - self-checking bench for the four-lane un-striping mux
module tb_mux_4x1_8bits_unstripe;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       reset_L = 1'b0;
   logic [7:0] data_in0 = '0, data_in1 = '0, data_in2 = '0, data_in3 = '0;
   logic       valid_in0 = 1'b0, valid_in1 = 1'b0, valid_in2 = 1'b0, valid_in3 = 1'b0;
   logic [7:0] data_out;
   logic       valid_out;
   logic [1:0] lane_sel;
   logic       overflow;
   logic [3:0] lane_full;

   always #5 clk = ~clk;

   mux_4x1_8bits_unstripe #(.WIDTH(8), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset_L(reset_L),
      .data_in0(data_in0), .data_in1(data_in1), .data_in2(data_in2), .data_in3(data_in3),
      .valid_in0(valid_in0), .valid_in1(valid_in1), .valid_in2(valid_in2), .valid_in3(valid_in3),
      .data_out(data_out), .valid_out(valid_out), .lane_sel(lane_sel),
      .overflow(overflow), .lane_full(lane_full)
   );

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference model: one queue per lane, a round-robin index, a sticky drop flag.
   logic [7:0] q [4][$];
   int         m_sel;
   logic [7:0] m_dout;
   logic       m_vout;
   logic       m_ovf;

   task automatic model_reset();
      for (int n = 0; n < 4; n++) q[n].delete();
      m_sel = 0; m_dout = '0; m_vout = 1'b0; m_ovf = 1'b0;
   endtask

   task automatic model_edge(input logic [3:0] v, input logic [31:0] d);
      if (q[m_sel].size() > 0) begin
         m_dout = q[m_sel].pop_front();
         m_vout = 1'b1;
         m_sel  = (m_sel + 1) % 4;
      end else begin
         m_vout = 1'b0;
      end
      for (int n = 0; n < 4; n++) begin
         if (v[n]) begin
            if (q[n].size() < DEPTH) q[n].push_back(d[8*n +: 8]);
            else m_ovf = 1'b1;
         end
      end
   endtask

   task automatic step(input logic [3:0] v, input logic [31:0] d);
      logic [3:0] lf;
      @(negedge clk);
      valid_in0 = v[0]; valid_in1 = v[1]; valid_in2 = v[2]; valid_in3 = v[3];
      data_in0 = d[7:0]; data_in1 = d[15:8]; data_in2 = d[23:16]; data_in3 = d[31:24];
      @(posedge clk);
      if (!reset_L) model_reset();
      else model_edge(v, d);
      #1;
      for (int n = 0; n < 4; n++) lf[n] = (q[n].size() == DEPTH);
      chk("model_data_out", 32'(data_out), 32'(m_dout));
      chk("model_valid_out", 32'(valid_out), 32'(m_vout));
      chk("model_lane_sel", 32'(lane_sel), 32'(m_sel));
      chk("model_overflow", 32'(overflow), 32'(m_ovf));
      chk("model_lane_full", 32'(lane_full), 32'(lf));
   endtask

   task automatic do_reset();
      reset_L = 1'b0;
      step(4'h0, 32'h0);
      reset_L = 1'b1;
   endtask

   typedef struct {
      logic [3:0]  v;
      logic [31:0] d;
      logic        ev;
      logic [7:0]  ed;
      logic [1:0]  es;
      logic        eo;
      logic [3:0]  ef;
   } vec_t;

   function automatic vec_t mk(input logic [3:0] v, input logic [31:0] d, input logic ev,
                               input logic [7:0] ed, input logic [1:0] es, input logic eo,
                               input logic [3:0] ef);
      vec_t r;
      r.v = v; r.d = d; r.ev = ev; r.ed = ed; r.es = es; r.eo = eo; r.ef = ef;
      return r;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t       tbl[$];
      logic [7:0] drain [13];
      logic [3:0] v;
      logic [7:0] base;
      model_reset();

      // Reset held, release, then asynchronous reset mid-cycle with data pending.
      step(4'h0, 32'h0);
      step(4'hF, 32'h01020304);
      reset_L = 1'b1;
      step(4'hF, 32'hD3D2D1D0);
      step(4'h0, 32'h0);
      #2 reset_L = 1'b0;
      #1;
      chk("rst_data_out", 32'(data_out), 32'h0);
      chk("rst_valid_out", 32'(valid_out), 32'h0);
      chk("rst_lane_sel", 32'(lane_sel), 32'h0);
      chk("rst_overflow", 32'(overflow), 32'h0);
      chk("rst_lane_full", 32'(lane_full), 32'h0);
      model_reset();
      step(4'hF, 32'hEEEEEEEE);
      reset_L = 1'b1;
      repeat (3) begin
         step(4'h0, 32'h0);
         chk("post_rst_idle", 32'(valid_out), 32'h0);
      end

      // Aligned group, skew, and overflow with drain, as hand-derived vectors.
      tbl.push_back(mk(4'hF, 32'hA3A2A1A0, 0, 8'h00, 0, 0, 4'h0));
      tbl.push_back(mk(4'h0, 32'h0, 1, 8'hA0, 1, 0, 4'h0));
      tbl.push_back(mk(4'h0, 32'h0, 1, 8'hA1, 2, 0, 4'h0));
      tbl.push_back(mk(4'h0, 32'h0, 1, 8'hA2, 3, 0, 4'h0));
      tbl.push_back(mk(4'h0, 32'h0, 1, 8'hA3, 0, 0, 4'h0));
      tbl.push_back(mk(4'h0, 32'h0, 0, 8'hA3, 0, 0, 4'h0));
      tbl.push_back(mk(4'hB, 32'h13001110, 0, 8'hA3, 0, 0, 4'h0));
      tbl.push_back(mk(4'h0, 32'h0, 1, 8'h10, 1, 0, 4'h0));
      tbl.push_back(mk(4'h0, 32'h0, 1, 8'h11, 2, 0, 4'h0));
      tbl.push_back(mk(4'h4, 32'h00120000, 0, 8'h11, 2, 0, 4'h0));
      tbl.push_back(mk(4'h0, 32'h0, 1, 8'h12, 3, 0, 4'h0));
      tbl.push_back(mk(4'h0, 32'h0, 1, 8'h13, 0, 0, 4'h0));
      tbl.push_back(mk(4'h0, 32'h0, 0, 8'h13, 0, 0, 4'h0));
      for (int i = 0; i < 4; i++)
         tbl.push_back(mk(4'h2, {16'h0, 8'(32'h20 + i), 8'h0}, 0, 8'h13, 0, 0, (i == 3) ? 4'h2 : 4'h0));
      tbl.push_back(mk(4'h2, 32'h00002400, 0, 8'h13, 0, 1, 4'h2));
      tbl.push_back(mk(4'hD, 32'h70600040, 0, 8'h13, 0, 1, 4'h2));
      tbl.push_back(mk(4'hD, 32'h71610041, 1, 8'h40, 1, 1, 4'h2));
      tbl.push_back(mk(4'hD, 32'h72620042, 1, 8'h20, 2, 1, 4'h0));
      tbl.push_back(mk(4'hD, 32'h73630043, 1, 8'h60, 3, 1, 4'h8));
      drain = '{8'h70, 8'h41, 8'h21, 8'h61, 8'h71, 8'h42, 8'h22, 8'h62,
                8'h72, 8'h43, 8'h23, 8'h63, 8'h73};
      for (int i = 0; i < 13; i++)
         tbl.push_back(mk(4'h0, 32'h0, 1, drain[i], 2'(i % 4), 1, 4'h0));
      tbl.push_back(mk(4'h0, 32'h0, 0, 8'h73, 0, 1, 4'h0));

      do_reset();
      foreach (tbl[i]) begin
         step(tbl[i].v, tbl[i].d);
         chk($sformatf("tbl%0d_valid", i), 32'(valid_out), 32'(tbl[i].ev));
         chk($sformatf("tbl%0d_data", i), 32'(data_out), 32'(tbl[i].ed));
         chk($sformatf("tbl%0d_sel", i), 32'(lane_sel), 32'(tbl[i].es));
         chk($sformatf("tbl%0d_ovf", i), 32'(overflow), 32'(tbl[i].eo));
         chk($sformatf("tbl%0d_full", i), 32'(lane_full), 32'(tbl[i].ef));
      end

      // Full lane 0 reaches the head while a new byte arrives on the same edge.
      do_reset();
      step(4'h1, 32'h0000002F);
      step(4'h0, 32'h0);
      for (int i = 0; i < 4; i++) step(4'h1, 32'(8'h30 + i));
      chk("fp_full_before", 32'(lane_full[0]), 32'h1);
      step(4'hE, 32'hB3B2B100);
      repeat (3) step(4'h0, 32'h0);
      chk("fp_sel_before", 32'(lane_sel), 32'h0);
      step(4'h1, 32'h00000034);
      chk("fp_data", 32'(data_out), 32'h30);
      chk("fp_valid", 32'(valid_out), 32'h1);
      chk("fp_overflow", 32'(overflow), 32'h0);
      chk("fp_full_after", 32'(lane_full[0]), 32'h1);

      // Three aligned groups back to back: continuous output across pointer wrap.
      do_reset();
      for (int s = 0; s < 13; s++) begin
         if (s % 4 == 0 && s < 12) begin
            base = 8'(32'h80 + s);
            step(4'hF, {base + 8'd3, base + 8'd2, base + 8'd1, base});
         end else begin
            step(4'h0, 32'h0);
         end
         chk($sformatf("wrap%0d_valid", s), 32'(valid_out), (s > 0) ? 32'h1 : 32'h0);
         if (s > 0) chk($sformatf("wrap%0d_data", s), 32'(data_out), 32'h80 + 32'(s - 1));
      end
      chk("wrap_overflow", 32'(overflow), 32'h0);

      // Random per-lane traffic, including overload, against the model.
      do_reset();
      repeat (300) begin
         for (int n = 0; n < 4; n++) v[n] = ($urandom_range(0, 2) == 0);
         step(v, $urandom);
      end

      // Random aligned striping with random gaps must never overflow.
      do_reset();
      repeat (40) begin
         step(4'hF, $urandom);
         repeat ($urandom_range(3, 5)) step(4'h0, 32'h0);
      end
      chk("aligned_no_overflow", 32'(overflow), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
